alu_cmd_initiator: RTL
======================

ALU_CMD_INITIATOR -- requirements
Module: alu_cmd_initiator

Interface
REQ-001 Parameters: WIDTH, 8, operand width; CMD_WIDTH, 4, command width; RES_LAT, 1, cycles from complete operands to RES valid; MUL_LAT, 2, same for arithmetic CMD 9/10.
REQ-002 Ports: clk input 1 clock; rst_n input 1 reset.
REQ-003 Ports: req_valid input 1; req_ready output 1; req_mode input 1; req_cmd input CMD_WIDTH; req_opa input WIDTH; req_opb input WIDTH; req_cin input 1; req_split input 1 (split operand delivery); req_gap input 4 (idle cycles between operands).
REQ-004 ALU-facing outputs: CE 1; MODE 1; CMD CMD_WIDTH; INP_VALID 2; OPA WIDTH; OPB WIDTH; CIN 1.
REQ-005 ALU-facing inputs: RES WIDTH+1; ERR, OFLOW, COUT, G, L, E, 1 each.
REQ-006 Response: rsp_valid output 1; rsp_ready input 1; rsp_res output WIDTH+1; rsp_flags output 6 {ERR,OFLOW,COUT,G,L,E}.
REQ-007 One clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-008 Operand class decoded from (mode,cmd): arith both = 0-3,8,9,10; arith A-only = 4,5; arith B-only = 6,7; logic both = 0-5,12,13; logic A-only = 6,8,9; logic B-only = 7,10,11; all others illegal.
REQ-009 FSM states IDLE, FIRST, GAP, DRIVE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-010 IDLE: handshake at cycle T latches request; next state FIRST if req_split and class both, else DRIVE.
REQ-011 FIRST (1 cycle): CE=1, INP_VALID=01, OPA driven, OPB=0; next GAP if req_gap>0 else DRIVE.
REQ-012 GAP: CE=1, INP_VALID=01 held for exactly req_gap cycles (max 15, satisfies 16-cycle window), then DRIVE.
REQ-013 DRIVE (1 cycle): INP_VALID = 11 (both), 01 (A-only), 10 (B-only), 00 (illegal); unused operand driven 0; CE=1.
REQ-014 MODE, CMD, CIN SHALL stay constant from FIRST through WAIT.
REQ-015 WAIT: CE=1, all ALU inputs held; latency L = MUL_LAT if mode=1 and cmd in {9,10}, else RES_LAT; RES and flags captured on the rising edge ending cycle D+L (D = DRIVE cycle); then RESP.
REQ-016 RESP: rsp_valid=1, rsp_res/rsp_flags stable until rsp_valid&rsp_ready; then IDLE; CE=0.
REQ-017 CE=0 and INP_VALID=00 in IDLE and RESP; ALU data outputs hold last values there.
REQ-018 Non-split latency: req accept T -> DRIVE T+1 -> rsp_valid T+2+L; back-to-back accept earliest one cycle after response handshake.
REQ-019 Illegal command still completes a full transaction; ERR reported as returned by ALU.
REQ-020 req_split ignored for non-both classes; req_gap ignored when req_split=0.
REQ-021 Response backpressure indefinite; no timeout.

Reset
REQ-022 rst_n low asynchronously forces IDLE; all outputs 0 except req_ready which is 1 after release.
REQ-023 Reset mid-transaction discards it; no response produced; CE drops immediately.

Structure
REQ-024 Shared package holds WIDTH/CMD_WIDTH defaults, FSM state enum, operand-class enum, command-code constants.
REQ-025 Sub-module alu_opclass_decode (combinational mode/cmd -> class) is used by this block and reusable by checkers.

Verification
REQ-026 mode=1 cmd=0 opa=8'h05 opb=8'h03 split=0 -> DRIVE INP_VALID=11 one cycle after accept, rsp_res=9'h008 at T+3.
REQ-027 mode=1 cmd=9 -> capture after 2 cycles, rsp_valid at T+4; CMD/MODE constant across WAIT.
REQ-028 mode=0 cmd=1 split=1 gap=4 -> INP_VALID 01 for 5 cycles, then 11 one cycle, OPA constant throughout.
REQ-029 mode=0 cmd=8 opb=8'hFF -> INP_VALID=01, OPB driven 0; mode=1 cmd=14 -> INP_VALID=00, rsp_flags ERR bit = ALU ERR.
REQ-030 rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_res stable, req_ready 0, CE 0.
REQ-031 rst_n low during GAP -> CE=0 same cycle, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/alu_cmd_initiator_pkg.sv
// Shared types and constants for the ALU command initiator and its checkers.
// Holds the FSM state set, the operand-class set and the multiply command codes.
package alu_cmd_initiator_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CMD_WIDTH = 4;

    // Arithmetic commands that use the longer result latency
    localparam int CMD_MUL_INC = 9;
    localparam int CMD_MUL_SHL = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRIVE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CLS_BOTH    = 2'd0,
        CLS_A_ONLY  = 2'd1,
        CLS_B_ONLY  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } opclass_e;

    // INP_VALID pattern presented while the full operand set is driven
    function automatic logic [1:0] class_inp_valid(opclass_e c);
        case (c)
            CLS_BOTH:   return 2'b11;
            CLS_A_ONLY: return 2'b01;
            CLS_B_ONLY: return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_initiator_if.sv
// Request, ALU-facing and response signal bundle for the ALU command initiator.
// master = initiator side, slave = requester/ALU/consumer side.
interface alu_cmd_initiator_if
    import alu_cmd_initiator_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CMD_WIDTH = DEF_CMD_WIDTH
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_mode;
    logic [CMD_WIDTH-1:0] req_cmd;
    logic [WIDTH-1:0]     req_opa;
    logic [WIDTH-1:0]     req_opb;
    logic                 req_cin;
    logic                 req_split;
    logic [3:0]           req_gap;

    logic                 CE;
    logic                 MODE;
    logic [CMD_WIDTH-1:0] CMD;
    logic [1:0]           INP_VALID;
    logic [WIDTH-1:0]     OPA;
    logic [WIDTH-1:0]     OPB;
    logic                 CIN;

    logic [WIDTH:0]       RES;
    logic                 ERR;
    logic                 OFLOW;
    logic                 COUT;
    logic                 G;
    logic                 L;
    logic                 E;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WIDTH:0]       rsp_res;
    logic [5:0]           rsp_flags;

    modport master (
        input  req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, req_split, req_gap,
        output req_ready,
        output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        input  RES, ERR, OFLOW, COUT, G, L, E,
        output rsp_valid, rsp_res, rsp_flags,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, req_split, req_gap,
        input  req_ready,
        input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        output RES, ERR, OFLOW, COUT, G, L, E,
        input  rsp_valid, rsp_res, rsp_flags,
        output rsp_ready
    );

endinterface

// File: rtl/alu_opclass_decode.sv
// Combinational decode of (mode, cmd) into the operand class the ALU expects.
// Reusable by protocol checkers that need the same classification.
module alu_opclass_decode
    import alu_cmd_initiator_pkg::*;
#(
    parameter int CMD_WIDTH = DEF_CMD_WIDTH
) (
    input  logic                 mode_i,
    input  logic [CMD_WIDTH-1:0] cmd_i,
    output opclass_e             cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        if (mode_i) begin
            case (cmd_i)
                CMD_WIDTH'(0), CMD_WIDTH'(1), CMD_WIDTH'(2), CMD_WIDTH'(3),
                CMD_WIDTH'(8), CMD_WIDTH'(9), CMD_WIDTH'(10): cls_o = CLS_BOTH;
                CMD_WIDTH'(4), CMD_WIDTH'(5):                 cls_o = CLS_A_ONLY;
                CMD_WIDTH'(6), CMD_WIDTH'(7):                 cls_o = CLS_B_ONLY;
                default:                                      cls_o = CLS_ILLEGAL;
            endcase
        end else begin
            case (cmd_i)
                CMD_WIDTH'(0), CMD_WIDTH'(1), CMD_WIDTH'(2), CMD_WIDTH'(3),
                CMD_WIDTH'(4), CMD_WIDTH'(5), CMD_WIDTH'(12), CMD_WIDTH'(13): cls_o = CLS_BOTH;
                CMD_WIDTH'(6), CMD_WIDTH'(8), CMD_WIDTH'(9):                  cls_o = CLS_A_ONLY;
                CMD_WIDTH'(7), CMD_WIDTH'(10), CMD_WIDTH'(11):                cls_o = CLS_B_ONLY;
                default:                                                      cls_o = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_initiator.sv
// Sequences one ALU command at a time: optional split operand delivery with a gap,
// a drive cycle, a latency wait, then a held response until it is accepted.
module alu_cmd_initiator
    import alu_cmd_initiator_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CMD_WIDTH = DEF_CMD_WIDTH,
    parameter int RES_LAT   = 1,
    parameter int MUL_LAT   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_cmd_initiator_if.master bus
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] FIRST = ST_FIRST;
    localparam logic [2:0] GAP   = ST_GAP;
    localparam logic [2:0] DRIVE = ST_DRIVE;
    localparam logic [2:0] WAIT  = ST_WAIT;
    localparam logic [2:0] RESP  = ST_RESP;

    logic [2:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 mode_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic [WIDTH-1:0]     opa_q, opb_q;
    logic                 cin_q;
    logic [3:0]           gap_q;
    opclass_e             cls_q;
    logic [WIDTH:0]       res_q;
    logic [5:0]           flags_q;

    opclass_e             req_cls;
    logic                 is_mul;
    logic                 pre_drive;
    logic                 last_wait;
    logic [1:0]           cls_iv;

    alu_opclass_decode #(.CMD_WIDTH(CMD_WIDTH)) u_dec (
        .mode_i (bus.req_mode),
        .cmd_i  (bus.req_cmd),
        .cls_o  (req_cls)
    );

    assign is_mul    = mode_q && (cmd_q == CMD_WIDTH'(CMD_MUL_INC) || cmd_q == CMD_WIDTH'(CMD_MUL_SHL));
    assign pre_drive = (state_q == FIRST) || (state_q == GAP);
    // A latency parameter of 0 is treated as 1 so WAIT can never stall
    assign last_wait = (state_q == WAIT) && (cnt_q <= 8'd1);
    assign cls_iv    = class_inp_valid(cls_q);

    // cnt_q counts remaining GAP cycles, then remaining WAIT cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (bus.req_valid) state_d = (bus.req_split && req_cls == CLS_BOTH) ? FIRST : DRIVE;
            FIRST: begin
                if (gap_q != 4'd0) begin
                    state_d = GAP;
                    cnt_d   = {4'b0, gap_q};
                end else begin
                    state_d = DRIVE;
                end
            end
            GAP: begin
                if (cnt_q <= 8'd1) state_d = DRIVE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            DRIVE: begin
                state_d = WAIT;
                cnt_d   = is_mul ? 8'(MUL_LAT) : 8'(RES_LAT);
            end
            WAIT: begin
                if (last_wait) state_d = RESP;
                else           cnt_d   = cnt_q - 8'd1;
            end
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cin_q   <= 1'b0;
            gap_q   <= '0;
            cls_q   <= CLS_ILLEGAL;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && bus.req_valid) begin
                mode_q <= bus.req_mode;
                cmd_q  <= bus.req_cmd;
                opa_q  <= bus.req_opa;
                opb_q  <= bus.req_opb;
                cin_q  <= bus.req_cin;
                gap_q  <= bus.req_gap;
                cls_q  <= req_cls;
            end
            if (last_wait) begin
                res_q   <= bus.RES;
                flags_q <= {bus.ERR, bus.OFLOW, bus.COUT, bus.G, bus.L, bus.E};
            end
        end
    end

    // Operand outputs are a function of held request state, so they keep their
    // last driven values through RESP and IDLE without extra registers.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.CE        = pre_drive || (state_q == DRIVE) || (state_q == WAIT);
    assign bus.INP_VALID = pre_drive ? 2'b01 :
                           ((state_q == DRIVE) || (state_q == WAIT)) ? cls_iv : 2'b00;
    assign bus.OPA       = cls_iv[0] ? opa_q : '0;
    assign bus.OPB       = (cls_iv[1] && !pre_drive) ? opb_q : '0;
    assign bus.MODE      = mode_q;
    assign bus.CMD       = cmd_q;
    assign bus.CIN       = cin_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_res   = res_q;
    assign bus.rsp_flags = flags_q;

endmodule
